rshifter_sat: RTL and testbench

- Narrowing counterpart of the fixed-point widening shifter in the FFT datapath.
- Takes a signed 2*DATA_WIDTH value and scales it back to DATA_WIDTH: arithmetic right shift by RSHIFT_AMOUNT, round-half-up, saturate.
- Used on butterfly and twiddle-multiply outputs before writeback to sample memory.
- Two-stage valid/ready pipeline, backpressure-capable, with per-sample and sticky overflow flags.

---
 rtl/rshifter_sat_pkg.sv | 11 +
 rtl/rshifter_sat_sat_round_core.sv | 32 +++
 rtl/rshifter_sat.sv | 96 +++++++++
 tb/tb_rshifter_sat.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rshifter_sat_pkg.sv
// rtl/rshifter_sat_pkg.sv - shared FFT fixed-point constants for the widening/narrowing shifters
package rshifter_sat_pkg;

   localparam int FXP_DATA_WIDTH    = 16;
   localparam int FXP_RSHIFT_AMOUNT = 8;

   // Saturation bounds for the default sample width
   localparam logic signed [FXP_DATA_WIDTH-1:0] MAX_POS = {1'b0, {(FXP_DATA_WIDTH-1){1'b1}}};
   localparam logic signed [FXP_DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(FXP_DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/rshifter_sat_sat_round_core.sv
// rtl/rshifter_sat_sat_round_core.sv - combinational arithmetic shift, saturate and overflow flag
module sat_round_core
   import rshifter_sat_pkg::*;
#(
   parameter int DATA_WIDTH    = FXP_DATA_WIDTH,
   parameter int RSHIFT_AMOUNT = FXP_RSHIFT_AMOUNT
) (
   input  logic signed [2*DATA_WIDTH:0] sum,
   output logic [DATA_WIDTH-1:0]        d,
   output logic                         ovf
);

   localparam int SW = 2*DATA_WIDTH + 1;
   localparam logic signed [SW-1:0] HI = {{(DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [SW-1:0] LO = {{(DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   logic signed [SW-1:0] shifted;

   always_comb begin
      shifted = sum >>> RSHIFT_AMOUNT;
      d       = shifted[DATA_WIDTH-1:0];
      ovf     = 1'b0;
      if (shifted > HI) begin
         d   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
         ovf = 1'b1;
      end else if (shifted < LO) begin
         d   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
         ovf = 1'b1;
      end
   end

endmodule

// File: rtl/rshifter_sat.sv
// rtl/rshifter_sat.sv - two-stage round/shift/saturate narrower; RSHIFTER_SAT_CNT_EN adds sat_count
module rshifter_sat
   import rshifter_sat_pkg::*;
#(
   parameter int DATA_WIDTH    = FXP_DATA_WIDTH,
   parameter int RSHIFT_AMOUNT = FXP_RSHIFT_AMOUNT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2*DATA_WIDTH-1:0] D_in,
   input  logic                    D_in_valid,
   output logic                    D_in_ready,
   output logic [DATA_WIDTH-1:0]   D_out,
   output logic                    D_out_valid,
   input  logic                    D_out_ready,
   output logic                    ovf,
   output logic                    ovf_sticky,
`ifdef RSHIFTER_SAT_CNT_EN
   output logic [15:0]             sat_count,
`endif
   input  logic                    clr_sticky
);

   localparam int SW      = 2*DATA_WIDTH + 1;
   localparam int RND_POS = (RSHIFT_AMOUNT > 0) ? RSHIFT_AMOUNT - 1 : 0;
   localparam logic [SW-1:0] RND = (RSHIFT_AMOUNT > 0) ? (SW'(1) << RND_POS) : '0;

   logic            s1_valid, s2_valid;
   logic [SW-1:0]   s1_sum, sum_in;
   logic            s1_load, s2_load, out_xfer;
   logic [DATA_WIDTH-1:0] core_d;
   logic            core_ovf;

   // Extra sum bit lets rounding past max positive reach the saturation check
   assign sum_in = {D_in[2*DATA_WIDTH-1], D_in} + RND;

   assign s2_load    = !s2_valid || D_out_ready;
   assign s1_load    = !s1_valid || s2_load;
   assign D_in_ready = !s1_valid || !s2_valid || D_out_ready;
   // Gating with rst keeps the reset cycle from completing an output transfer
   assign D_out_valid = s2_valid && !rst;
   assign out_xfer    = D_out_valid && D_out_ready;

   sat_round_core #(
      .DATA_WIDTH    (DATA_WIDTH),
      .RSHIFT_AMOUNT (RSHIFT_AMOUNT)
   ) u_core (
      .sum (s1_sum),
      .d   (core_d),
      .ovf (core_ovf)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
      end else if (s1_load) begin
         s1_valid <= D_in_valid;
         if (D_in_valid) s1_sum <= sum_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid <= 1'b0;
         D_out    <= '0;
         ovf      <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            D_out <= core_d;
            ovf   <= core_ovf;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                  ovf_sticky <= 1'b0;
      else if (out_xfer && ovf) ovf_sticky <= 1'b1;
      else if (clr_sticky)      ovf_sticky <= 1'b0;
   end

`ifdef RSHIFTER_SAT_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         sat_count <= '0;
      end else if (out_xfer && ovf) begin
         if (clr_sticky)               sat_count <= 16'd1;
         else if (sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
      end else if (clr_sticky) begin
         sat_count <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_rshifter_sat.sv
// tb/tb_rshifter_sat.sv - scoreboard bench for rshifter_sat against an integer reference model
module tb_rshifter_sat;

   localparam int DW = 16;
   localparam int SH = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [31:0]   D_in = '0;
   logic          D_in_valid = 1'b0;
   logic          D_in_ready;
   logic [15:0]   D_out;
   logic          D_out_valid;
   logic          D_out_ready = 1'b1;
   logic          ovf;
   logic          ovf_sticky;
   logic          clr_sticky = 1'b0;
`ifdef RSHIFTER_SAT_CNT_EN
   logic [15:0]   sat_count;
`endif

   rshifter_sat #(.DATA_WIDTH(DW), .RSHIFT_AMOUNT(SH)) dut (
      .clk         (clk),
      .rst         (rst),
      .D_in        (D_in),
      .D_in_valid  (D_in_valid),
      .D_in_ready  (D_in_ready),
      .D_out       (D_out),
      .D_out_valid (D_out_valid),
      .D_out_ready (D_out_ready),
      .ovf         (ovf),
      .ovf_sticky  (ovf_sticky),
`ifdef RSHIFTER_SAT_CNT_EN
      .sat_count   (sat_count),
`endif
      .clr_sticky  (clr_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] d;
      logic        ovf;
   } exp_t;

   exp_t        q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          ready_mode = 0;
   logic        exp_sticky = 1'b0;
   logic [15:0] exp_cnt = '0;
   logic        held_v = 1'b0;
   logic [16:0] held = '0;

   function automatic exp_t model(input logic [31:0] x);
      exp_t   e;
      longint v, s;
      v = longint'($signed(x));
      s = (v + ((SH > 0) ? (longint'(1) <<< (SH - 1)) : 0)) >>> SH;
      if (s > 32767) begin
         e.d = 16'h7FFF; e.ovf = 1'b1;
      end else if (s < -32768) begin
         e.d = 16'h8000; e.ovf = 1'b1;
      end else begin
         e.d = s[15:0];  e.ovf = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       D_out_ready = 1'b1;
         1:       D_out_ready = 1'b0;
         default: D_out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   always @(negedge clk) begin
      exp_t e;
      logic xo;
      if (rst) begin
         q.delete();
         exp_sticky = 1'b0;
         exp_cnt    = '0;
         held_v     = 1'b0;
      end else begin
         xo = 1'b0;
         check("ovf_sticky", 32'(ovf_sticky), 32'(exp_sticky));
`ifdef RSHIFTER_SAT_CNT_EN
         check("sat_count", 32'(sat_count), 32'(exp_cnt));
`endif
         if (held_v && D_out_valid) check("stall_hold", 32'({ovf, D_out}), 32'(held));
         if (D_out_valid && D_out_ready) begin
            if (q.size() == 0) begin
               check("unexpected_out", 32'(D_out_valid), 32'd0);
            end else begin
               e = q.pop_front();
               check("D_out", 32'(D_out), 32'(e.d));
               check("ovf", 32'(ovf), 32'(e.ovf));
               xo = e.ovf;
            end
            held_v = 1'b0;
         end else if (D_out_valid) begin
            held_v = 1'b1;
            held   = {ovf, D_out};
         end else begin
            held_v = 1'b0;
         end
         if (xo)              exp_sticky = 1'b1;
         else if (clr_sticky) exp_sticky = 1'b0;
         if (xo) begin
            if (clr_sticky)              exp_cnt = 16'd1;
            else if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
         end else if (clr_sticky) begin
            exp_cnt = '0;
         end
      end
   end

   task automatic send(input logic [31:0] x);
      bit ok = 0;
      D_in       = x;
      D_in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (D_in_ready) begin
            q.push_back(model(x));
            ok = 1;
         end
         @(posedge clk);
         #1;
      end
      if (!ok) check("send_timeout", 32'd1, 32'd0);
   endtask

   task automatic idle(input int n);
      D_in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_state();
      check("rst_D_out_valid", 32'(D_out_valid), 32'd0);
      check("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
      check("rst_D_in_ready", 32'(D_in_ready), 32'd1);
`ifdef RSHIFTER_SAT_CNT_EN
      check("rst_sat_count", 32'(sat_count), 32'd0);
`endif
   endtask

   initial begin
      logic [31:0] r, x;
      bit done;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state();
      check("rst_D_out", 32'(D_out), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);

      // Directed values from the test plan, with a latency probe on the first
      send(32'h0001_2380);
      D_in_valid = 1'b0;
      check("latency_early", 32'(D_out_valid), 32'd0);
      @(posedge clk);
      #1;
      check("latency_2cyc", 32'(D_out_valid), 32'd1);
      send(32'hFFFF_FF80);
      send(32'h0080_0000);
      send(32'hFF7F_FF00);
      idle(4);
      clr_sticky = 1'b1;
      idle(1);
      clr_sticky = 1'b0;
      idle(2);

      // Backpressure: two samples fill the pipe, third must stall
      ready_mode = 1;
      idle(1);
      send(32'h0000_0100);
      send(32'h0000_0200);
      D_in       = 32'h0000_0300;
      D_in_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("bp_D_in_ready", 32'(D_in_ready), 32'd0);
         check("bp_D_out", 32'(D_out), 32'h0001);
         @(posedge clk);
         #1;
      end
      ready_mode = 0;
      send(32'h0000_0300);
      send(32'h0000_0400);
      idle(6);

      // Reset with two saturating samples in flight
      send(32'h7FFF_0000);
      send(32'h8000_0000);
      D_in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state();
      idle(6);

      // Randomized traffic with random backpressure and clears
      ready_mode = 2;
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         case ($urandom_range(0, 3))
            0: x = r;
            1: x = {{8{r[23]}}, r[23:0]};
            2: x = 32'h007F_FF7F + 32'($urandom_range(0, 2)) - 32'd1;
            default: x = 32'hFF7F_FF80 + 32'($urandom_range(0, 2)) - 32'd1;
         endcase
         clr_sticky = ($urandom_range(0, 7) == 0);
         send(x);
         if ($urandom_range(0, 5) == 0) idle(1);
      end
      clr_sticky = 1'b0;
      D_in_valid = 1'b0;

      ready_mode = 0;
      done = 0;
      for (int i = 0; i < 100 && !done; i++) begin
         @(posedge clk);
         #1;
         if (q.size() == 0 && !D_out_valid) done = 1;
      end
      check("drain", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
